bram_rd_stat_accum: RTL and testbench



---
 rtl/bram_rd_stat_accum.sv | 119 +++++++++++
 tb/tb_bram_rd_stat_accum.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_stat_accum.sv
// bram_rd_stat_accum: streaming sum/min/max over a programmed number of beats
// taken from the read-back stream of simple_bram_ctrl. Its idle/running/done
// handshake matches the controller's, so one i_run can start both blocks.
// Optional feature macro: BRAM_STAT_MINMAX_EN. When it is defined, the running
// min/max registers are built. When it is undefined, o_max and o_min read as 0.
module bram_rd_stat_accum #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_run,
    input  logic [CWIDTH-1:0]        i_num_cnt,
    output logic                     o_idle,
    output logic                     o_running,
    output logic                     o_done,
    input  logic                     i_valid,
    input  logic [DWIDTH-1:0]        i_data,
    output logic [DWIDTH+CWIDTH-1:0] o_sum,
    output logic [DWIDTH-1:0]        o_max,
    output logic [DWIDTH-1:0]        o_min
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CWIDTH-1:0] cnt_r;
    logic [CWIDTH-1:0] num_r;
    logic              start;
    logic              accept;
    logic              last_beat;

    assign start     = (state == S_IDLE) && i_run;
    assign accept    = (state == S_RUN) && i_valid;
    assign last_beat = (cnt_r == num_r - 1'b1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_run) begin
                    state_nxt = (i_num_cnt != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (accept && last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_idle    = (state == S_IDLE);
    assign o_running = (state == S_RUN);
    assign o_done    = (state == S_DONE);

    // Beat counter, target count and sum accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
            num_r <= '0;
            o_sum <= '0;
        end else if (start) begin
            cnt_r <= '0;
            num_r <= i_num_cnt;
            o_sum <= '0;
        end else if (accept) begin
            cnt_r <= cnt_r + 1'b1;
            o_sum <= o_sum + (DWIDTH+CWIDTH)'(i_data);
        end
    end

`ifdef BRAM_STAT_MINMAX_EN
    logic [DWIDTH-1:0] max_r;
    logic [DWIDTH-1:0] min_r;

    // Running unsigned max/min, seeded so the first beat always replaces both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_r <= '0;
            min_r <= '0;
        end else if (start) begin
            max_r <= '0;
            min_r <= '1;
        end else if (accept) begin
            if (i_data > max_r) begin
                max_r <= i_data;
            end
            if (i_data < min_r) begin
                min_r <= i_data;
            end
        end
    end

    assign o_max = max_r;
    assign o_min = min_r;
`else
    assign o_max = '0;
    assign o_min = '0;
`endif

endmodule

// File: tb/tb_bram_rd_stat_accum.sv
// Directed bench for bram_rd_stat_accum. The min/max expectations follow
// BRAM_STAT_MINMAX_EN, so the bench covers both builds.
module tb_bram_rd_stat_accum;

    localparam int DWIDTH = 16;
    localparam int CWIDTH = 7;

`ifdef BRAM_STAT_MINMAX_EN
    localparam bit MM_EN = 1'b1;
`else
    localparam bit MM_EN = 1'b0;
`endif

    logic                     clk;
    logic                     reset;
    logic                     i_run;
    logic [CWIDTH-1:0]        i_num_cnt;
    logic                     o_idle;
    logic                     o_running;
    logic                     o_done;
    logic                     i_valid;
    logic [DWIDTH-1:0]        i_data;
    logic [DWIDTH+CWIDTH-1:0] o_sum;
    logic [DWIDTH-1:0]        o_max;
    logic [DWIDTH-1:0]        o_min;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bram_rd_stat_accum #(
        .DWIDTH(DWIDTH),
        .CWIDTH(CWIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_run     (i_run),
        .i_num_cnt (i_num_cnt),
        .o_idle    (o_idle),
        .o_running (o_running),
        .o_done    (o_done),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_sum     (o_sum),
        .o_max     (o_max),
        .o_min     (o_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Pulse i_run for one rising edge, returning at the following falling edge
    task automatic start_run(input logic [CWIDTH-1:0] n);
        i_run     = 1'b1;
        i_num_cnt = n;
        @(negedge clk);
        i_run     = 1'b0;
    endtask

    // Present one valid beat for one rising edge
    task automatic beat(input logic [DWIDTH-1:0] d);
        i_valid = 1'b1;
        i_data  = d;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        i_run     = 1'b0;
        i_num_cnt = '0;
        i_valid   = 1'b0;
        i_data    = '0;
        repeat (3) @(negedge clk);
        check("rst_idle",    32'(o_idle),    32'd1);
        check("rst_running", 32'(o_running), 32'd0);
        check("rst_done",    32'(o_done),    32'd0);
        check("rst_sum",     32'(o_sum),     32'd0);
        check("rst_max",     32'(o_max),     32'd0);
        check("rst_min",     32'(o_min),     32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full 100-beat run, data 0..99
        start_run(7'd100);
        check("full_running", 32'(o_running), 32'd1);
        for (int k = 0; k < 100; k++) begin
            beat(DWIDTH'(k));
            if (k == 98) check("full_done_early", 32'(o_done), 32'd0);
        end
        check("full_done",  32'(o_done), 32'd1);
        check("full_sum",   32'(o_sum),  32'd4950);
        check("full_max",   32'(o_max),  MM_EN ? 32'd99 : 32'd0);
        check("full_min",   32'(o_min),  32'd0);
        @(negedge clk);
        check("full_done_once", 32'(o_done), 32'd0);
        check("full_idle_after", 32'(o_idle), 32'd1);
        check("full_sum_hold",  32'(o_sum),  32'd4950);

        // Bubbles: 7,3,9,5 with two idle cycles between beats
        start_run(7'd4);
        beat(16'd7);
        repeat (2) begin
            check("bub_running", 32'(o_running), 32'd1);
            @(negedge clk);
        end
        beat(16'd3);
        repeat (2) begin
            check("bub_running", 32'(o_running), 32'd1);
            @(negedge clk);
        end
        beat(16'd9);
        repeat (2) begin
            check("bub_running", 32'(o_running), 32'd1);
            @(negedge clk);
        end
        check("bub_running_last", 32'(o_running), 32'd1);
        beat(16'd5);
        check("bub_done", 32'(o_done), 32'd1);
        check("bub_sum",  32'(o_sum),  32'd24);
        check("bub_max",  32'(o_max),  MM_EN ? 32'd9 : 32'd0);
        check("bub_min",  32'(o_min),  MM_EN ? 32'd3 : 32'd0);
        @(negedge clk);

        // Zero-count run
        start_run(7'd0);
        check("zero_done",    32'(o_done),    32'd1);
        check("zero_running", 32'(o_running), 32'd0);
        check("zero_sum",     32'(o_sum),     32'd0);
        check("zero_max",     32'(o_max),     32'd0);
        check("zero_min",     32'(o_min),     MM_EN ? 32'hFFFF : 32'd0);
        @(negedge clk);
        check("zero_idle", 32'(o_idle), 32'd1);

        // Ignored inputs: beats before i_run, and a second i_run mid-run
        beat(16'd50);
        beat(16'd50);
        check("ign_idle_sum", 32'(o_sum), 32'd0);
        start_run(7'd3);
        beat(16'd10);
        i_run     = 1'b1;
        i_num_cnt = 7'd2;
        beat(16'd10);
        i_run     = 1'b0;
        check("ign_no_early_done", 32'(o_done), 32'd0);
        beat(16'd10);
        check("ign_done", 32'(o_done), 32'd1);
        check("ign_sum",  32'(o_sum),  32'd30);
        check("ign_max",  32'(o_max),  MM_EN ? 32'd10 : 32'd0);
        check("ign_min",  32'(o_min),  MM_EN ? 32'd10 : 32'd0);
        beat(16'd50);
        check("ign_done_sum", 32'(o_sum), 32'd30);

        // Reset after 2 of 5 beats
        start_run(7'd5);
        beat(16'd7);
        beat(16'd7);
        reset = 1'b1;
        #1;
        check("mrst_idle",    32'(o_idle),    32'd1);
        check("mrst_running", 32'(o_running), 32'd0);
        check("mrst_done",    32'(o_done),    32'd0);
        check("mrst_sum",     32'(o_sum),     32'd0);
        check("mrst_max",     32'(o_max),     32'd0);
        check("mrst_min",     32'(o_min),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_no_done", 32'(o_done), 32'd0);
        check("mrst_idle2",   32'(o_idle), 32'd1);
        start_run(7'd5);
        for (int k = 0; k < 5; k++) beat(16'd1);
        check("post_done", 32'(o_done), 32'd1);
        check("post_sum",  32'(o_sum),  32'd5);
        check("post_max",  32'(o_max),  MM_EN ? 32'd1 : 32'd0);
        check("post_min",  32'(o_min),  MM_EN ? 32'd1 : 32'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
